// File: rtl/usr_irq_mc_if.sv
// Avalon-MM master bus carrying interrupt raise/clear writes (and optional readback)
// from usr_irq_mc to the interrupt-controller slave.
interface usr_irq_mc_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;

    modport master (
        output chipselect, address, read, write, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  chipselect, address, read, write, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/usr_irq_mc.sv
// Multi-channel user IRQ forwarder: synchronised level changes become round-robin Avalon writes.
// Optional macro IRQ_READBACK_EN adds a read-back-and-compare of each written register.
module usr_irq_mc #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  usr_irq_in,
    usr_irq_mc_if.master       irq_avalon_master,
    output logic               busy,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               rb_err
);
    localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef IRQ_READBACK_EN
    typedef enum logic [1:0] {StIdle, StWr, StRd, StChk} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWr} state_e;
`endif

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] s1_q, s2_q, s3_q;
    logic [NUM_CH-1:0] pend_q, pend_d, val_q, val_d;
    logic [PtrW-1:0]   ptr_q, ptr_d, ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              data_q, data_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              wr_done;
    logic              found;
    int unsigned       idx;
`ifdef IRQ_READBACK_EN
    logic              rb_bit_q, rb_bit_d;
    logic              rb_err_q, rb_err_d;
    logic              unused_rdata;
    assign unused_rdata = ^irq_avalon_master.readdata[31:1];
`else
    logic              unused_rdata;
    assign unused_rdata = ^irq_avalon_master.readdata;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_done = 1'b0;
        found   = 1'b0;
        idx     = 0;
`ifdef IRQ_READBACK_EN
        rb_bit_d = rb_bit_q;
        rb_err_d = rb_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Search starts at ptr and wraps; the first hit wins.
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    idx = 32'(ptr_q) + i;
                    if (idx >= NUM_CH) idx = idx - NUM_CH;
                    if (!found && pend_q[idx]) begin
                        found = 1'b1;
                        ch_d  = PtrW'(idx);
                    end
                end
                if (found) begin
                    state_d = StWr;
                    ptr_d   = (ch_d == PtrW'(NUM_CH - 1)) ? '0 : ch_d + PtrW'(1);
                    addr_d  = ADDR_W'(BASE_ADDR + 32'(ch_d));
                    data_d  = val_q[ch_d];
                end
            end
            StWr: begin
                if (!irq_avalon_master.waitrequest) begin
                    wr_done = 1'b1;
`ifdef IRQ_READBACK_EN
                    state_d = StRd;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef IRQ_READBACK_EN
            StRd: begin
                if (!irq_avalon_master.waitrequest) begin
                    rb_bit_d = irq_avalon_master.readdata[0];
                    state_d  = StChk;
                end
            end
            StChk: begin
                if (rb_bit_q != data_q) rb_err_d = 1'b1;
                state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // A new event in the completing cycle re-arms the channel without counting as a drop.
    always_comb begin
        pend_d = pend_q;
        val_d  = val_q;
        drop_d = drop_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (s2_q[c] != s3_q[c]) begin
                if (pend_q[c] && !(wr_done && ch_q == PtrW'(c)) && drop_d != '1) begin
                    drop_d = drop_d + CNT_W'(1);
                end
                pend_d[c] = 1'b1;
                val_d[c]  = s2_q[c];
            end else if (wr_done && ch_q == PtrW'(c)) begin
                pend_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            pend_q   <= '0;
            val_q    <= '0;
            ptr_q    <= '0;
            ch_q     <= '0;
            addr_q   <= '0;
            data_q   <= 1'b0;
            drop_q   <= '0;
`ifdef IRQ_READBACK_EN
            rb_bit_q <= 1'b0;
            rb_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s1_q     <= usr_irq_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            pend_q   <= pend_d;
            val_q    <= val_d;
            ptr_q    <= ptr_d;
            ch_q     <= ch_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
`ifdef IRQ_READBACK_EN
            rb_bit_q <= rb_bit_d;
            rb_err_q <= rb_err_d;
`endif
        end
    end

    assign irq_avalon_master.write     = (state_q == StWr);
    assign irq_avalon_master.address   = addr_q;
    assign irq_avalon_master.writedata = {31'b0, data_q};
`ifdef IRQ_READBACK_EN
    assign irq_avalon_master.chipselect = (state_q == StWr) || (state_q == StRd);
    assign irq_avalon_master.read       = (state_q == StRd);
    assign rb_err                       = rb_err_q;
`else
    assign irq_avalon_master.chipselect = (state_q == StWr);
    assign irq_avalon_master.read       = 1'b0;
    assign rb_err                       = 1'b0;
`endif
    assign busy     = (state_q != StIdle);
    assign drop_cnt = drop_q;
endmodule

// File: doc/usr_irq_mc.md
Name: usr_irq_mc

Overview:
Multi-channel successor to the single-line user IRQ forwarder. Takes NUM_CH asynchronous user interrupt lines and synchronises each one. Every level change becomes a per-channel pending event. Events are forwarded, one at a time under round-robin arbitration, as Avalon-MM master writes (1 = raise, 0 = clear) to a per-channel register in the interrupt-controller slave. Unlike the single-channel version it honours waitrequest, coalesces events, and counts dropped ones.

Parameters:
NUM_CH, 4, number of interrupt channels (1..16)
ADDR_W, 4, Avalon address width
BASE_ADDR, 0, word address of channel 0 register; channel c maps to BASE_ADDR + c (modulo 2^ADDR_W)
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
usr_irq_in  in  NUM_CH  asynchronous user interrupt levels
irq_avalon_master_chipselect  out  1  Avalon chipselect
irq_avalon_master_address  out  ADDR_W  Avalon word address
irq_avalon_master_read  out  1  Avalon read (only used with IRQ_READBACK_EN)
irq_avalon_master_write  out  1  Avalon write
irq_avalon_master_writedata  out  32  bit0 = level, bits 31:1 = 0
irq_avalon_master_waitrequest  in  1  slave stall
irq_avalon_master_readdata  in  32  slave read data
busy  out  1  high while the FSM is not in IDLE
drop_cnt  out  CNT_W  saturating count of coalesced events
rb_err  out  1  sticky readback mismatch (IRQ_READBACK_EN only, else tied 0)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs go to 0.
  - Sync flops go to 0; pending and value bits are cleared.
  - Round-robin pointer goes to 0; FSM goes to IDLE.
  - A transfer in flight is abandoned immediately.
- Synchroniser, per channel: s1 <= in, s2 <= s1, s3 <= s2. Edge event = s2 != s3.
- Pending state, per channel:
  - On an event: pend <= 1 and val <= s2.
  - If pend is already 1 at the event, drop_cnt increments, saturating at all-ones. val is overwritten (last value wins).
  - pend clears in the cycle the channel's write completes. If a new event for the same channel arrives that same cycle, the set wins, val takes the new level and drop_cnt is not incremented.
- Arbiter, evaluated only in IDLE:
  - Picks the first pending channel searching from ptr, ptr+1, ..., wrapping at NUM_CH.
  - On grant, ptr <= granted+1, wrapping to 0.
  - Channel index, address and data are latched at grant.
- FSM states: IDLE, WR, plus RD and CHK when readback is enabled.
  - IDLE -> WR when any channel is pending. Next cycle: chipselect=1, write=1, address=BASE_ADDR+ch, writedata={31'b0,val}.
  - WR holds all signals stable while waitrequest=1.
  - At the first clk edge with waitrequest=0: pend[ch] clears and the FSM returns to IDLE (or goes to RD with readback). chipselect and write drop the next cycle.
- Timing: minimum one idle cycle between transfers. Latency from the first clk edge sampling a new input level to write asserted is 4 clocks when the block is idle with nothing pending.
- Input pulses shorter than 2 clocks may be missed; this is acceptable.
- read is held 0 unless IRQ_READBACK_EN is defined.

Optional Feature:
Macro: IRQ_READBACK_EN.
- Defined:
  - After WR completes, the FSM enters RD: chipselect=1, read=1, same address, held while waitrequest=1.
  - At the completing edge, readdata[0] is captured and the FSM enters CHK.
  - CHK is one cycle. If the captured bit != the written val, rb_err sets and stays set until reset. The FSM then returns to IDLE.
- Undefined: RD/CHK do not exist, read=0, rb_err=0.

Test Plan:
- Reset then idle, all inputs 0 for 20 cycles -> no chipselect/write, busy=0, drop_cnt=0.
- NUM_CH=4, BASE_ADDR=4, ch2 rises, waitrequest=0 -> single write, address=6, writedata=1, 4 clocks after sampling. ch2 falls -> write address=6, data=0.
- ch0..3 rise in the same cycle -> four writes in order ch0, ch1, ch2, ch3, each data=1. Next simultaneous fall of ch3 and ch1 -> order ch1, ch3 (pointer at 0 after wrap).
- waitrequest held 1 for 5 cycles during a ch1 write -> address/data/write stable for 6 cycles, exactly one transfer accepted.
- ch0 toggles 0->1->0->1 (3-clock pulses) while the slave stalls 30 cycles -> drop_cnt=2, then exactly one further ch0 write with data=1.
- IRQ_READBACK_EN: slave returns readdata=0 after a write of 1 -> rb_err=1, stays 1 until rst.
